// File: rtl/placement_pkg.sv
// Shared types and the tetromino footprint table for the placement search engine.
package placement_pkg;

  typedef enum logic [2:0] {
    PIECE_I = 3'd0,
    PIECE_O = 3'd1,
    PIECE_T = 3'd2,
    PIECE_S = 3'd3,
    PIECE_Z = 3'd4,
    PIECE_J = 3'd5,
    PIECE_L = 3'd6
  } piece_e;

  localparam int NUM_PIECES = 7;
  localparam int NUM_ROT    = 4;
  // Widest footprint is 4 columns (horizontal I), so 3 bits suffice.
  localparam int FP_W_BITS  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  // Footprint width in columns for a piece in a given rotation.
  // Odd rotations are the "standing" orientations.
  function automatic logic [FP_W_BITS-1:0] footprint_w(input piece_e piece,
                                                        input logic [1:0] rot);
    logic [FP_W_BITS-1:0] w;
    case (piece)
      PIECE_I: w = rot[0] ? 3'd1 : 3'd4;
      PIECE_O: w = 3'd2;
      default: w = rot[0] ? 3'd2 : 3'd3;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/placement_score.sv
// Combinational fit scorer for one candidate footprint: checks that the
// footprint stays on the board and counts the free rows from the surface down.
module placement_score
  import placement_pkg::*;
#(
  parameter int COLS    = 10,
  parameter int ROWS    = 2,
  parameter int COL_W   = 4,
  parameter int SCORE_W = 3
) (
  input  logic [ROWS*COLS-1:0]  row_info,
  input  logic [COL_W-1:0]      col,
  input  logic [FP_W_BITS-1:0]  w,
  output logic                  legal,
  output logic [SCORE_W-1:0]    score
);

  logic [COLS-1:0] in_fp;
  logic [ROWS-1:0] row_free;

  assign legal = (int'(col) + int'(w)) <= COLS;

  // Column c is covered by the footprint when col <= c < col+w.
  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_fp_mask
      assign in_fp[gi] = (int'(col) <= gi) && (gi < int'(col) + int'(w));
    end
    for (gi = 0; gi < ROWS; gi++) begin : g_row_free
      assign row_free[gi] = ((row_info[gi*COLS +: COLS] & in_fp) == '0);
    end
  endgenerate

  // Score is the length of the unbroken run of free rows starting at row 0.
  always_comb begin : count_free_prefix
    logic        run;
    int unsigned cnt;
    run = 1'b1;
    cnt = 0;
    for (int r = 0; r < ROWS; r++) begin
      if (run && row_free[r]) cnt = cnt + 1;
      else                    run = 1'b0;
    end
    score = SCORE_W'(cnt);
  end

endmodule

// File: rtl/placement_search.sv
// Multi-cycle placement search: scans every (rotation, column) candidate, one
// per clock, and reports the best-scoring anchor for the requested piece.
module placement_search
  import placement_pkg::*;
#(
  parameter int COLS    = 10,
  parameter int ROWS    = 2,
  parameter int COL_W   = 4,
  parameter int SCORE_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_to_client,
  input  logic [3:0]           cur_block,
  input  logic [3:0]           rot_mask,
  input  logic [ROWS*COLS-1:0] row_info,
  output logic                 resp_from_client,
  output logic                 busy,
  output logic [COL_W-1:0]     opt_col,
  output logic [1:0]           opt_rotation,
  output logic                 opt_found,
  output logic [SCORE_W-1:0]   opt_score
);

  state_e               state_q, state_d;
  piece_e               piece_q, piece_d;
  logic [3:0]           mask_q, mask_d;
  logic [ROWS*COLS-1:0] rows_q, rows_d;
  logic [1:0]           rot_q, rot_d;
  logic [COL_W-1:0]     col_q, col_d;

  logic                 best_found_q, best_found_d;
  logic [SCORE_W-1:0]   best_score_q, best_score_d;
  logic [COL_W-1:0]     best_col_q, best_col_d;
  logic [1:0]           best_rot_q, best_rot_d;

  logic                 opt_found_q, opt_found_d;
  logic [SCORE_W-1:0]   opt_score_q, opt_score_d;
  logic [COL_W-1:0]     opt_col_q, opt_col_d;
  logic [1:0]           opt_rot_q, opt_rot_d;

  logic                 resp_q, resp_d;
  // An invalid piece answers one cycle after it is sampled.
  logic                 inv_q, inv_d;

  logic [FP_W_BITS-1:0] cand_w;
  logic                 cand_legal;
  logic [SCORE_W-1:0]   cand_score;
  logic                 cand_better;
  logic                 last_col;
  logic                 last_cand;

  assign cand_w = footprint_w(piece_q, rot_q);

  placement_score #(
    .COLS    (COLS),
    .ROWS    (ROWS),
    .COL_W   (COL_W),
    .SCORE_W (SCORE_W)
  ) u_score (
    .row_info (rows_q),
    .col      (col_q),
    .w        (cand_w),
    .legal    (cand_legal),
    .score    (cand_score)
  );

  // Strictly-greater replacement keeps the earliest candidate on ties.
  assign cand_better = cand_legal && mask_q[rot_q] && (cand_score > best_score_q);
  assign last_col    = (col_q == COL_W'(COLS - 1));
  assign last_cand   = last_col && (rot_q == 2'd3);

  // Next-state, candidate stepping, best tracking and response generation.
  always_comb begin
    state_d      = state_q;
    piece_d      = piece_q;
    mask_d       = mask_q;
    rows_d       = rows_q;
    rot_d        = rot_q;
    col_d        = col_q;
    best_found_d = best_found_q;
    best_score_d = best_score_q;
    best_col_d   = best_col_q;
    best_rot_d   = best_rot_q;
    opt_found_d  = opt_found_q;
    opt_score_d  = opt_score_q;
    opt_col_d    = opt_col_q;
    opt_rot_d    = opt_rot_q;
    resp_d       = 1'b0;
    inv_d        = 1'b0;

    if (inv_q) begin
      resp_d      = 1'b1;
      opt_found_d = 1'b0;
      opt_score_d = '0;
      opt_col_d   = '0;
      opt_rot_d   = '0;
    end

    case (state_q)
      IDLE: begin
        if (req_to_client) begin
          if (cur_block < 4'(NUM_PIECES)) begin
            piece_d      = piece_e'(cur_block[2:0]);
            mask_d       = rot_mask;
            rows_d       = row_info;
            rot_d        = '0;
            col_d        = '0;
            best_found_d = 1'b0;
            best_score_d = '0;
            best_col_d   = '0;
            best_rot_d   = '0;
            state_d      = SCAN;
          end else begin
            inv_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (cand_better) begin
          best_found_d = 1'b1;
          best_score_d = cand_score;
          best_col_d   = col_q;
          best_rot_d   = rot_q;
        end
        if (last_col) begin
          col_d = '0;
          rot_d = rot_q + 2'd1;
        end else begin
          col_d = col_q + COL_W'(1);
        end
        if (last_cand) begin
          opt_found_d = best_found_d;
          opt_score_d = best_score_d;
          opt_col_d   = best_col_d;
          opt_rot_d   = best_rot_d;
          resp_d      = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      piece_q      <= PIECE_I;
      mask_q       <= '0;
      rows_q       <= '0;
      rot_q        <= '0;
      col_q        <= '0;
      best_found_q <= 1'b0;
      best_score_q <= '0;
      best_col_q   <= '0;
      best_rot_q   <= '0;
      opt_found_q  <= 1'b0;
      opt_score_q  <= '0;
      opt_col_q    <= '0;
      opt_rot_q    <= '0;
      resp_q       <= 1'b0;
      inv_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      piece_q      <= piece_d;
      mask_q       <= mask_d;
      rows_q       <= rows_d;
      rot_q        <= rot_d;
      col_q        <= col_d;
      best_found_q <= best_found_d;
      best_score_q <= best_score_d;
      best_col_q   <= best_col_d;
      best_rot_q   <= best_rot_d;
      opt_found_q  <= opt_found_d;
      opt_score_q  <= opt_score_d;
      opt_col_q    <= opt_col_d;
      opt_rot_q    <= opt_rot_d;
      resp_q       <= resp_d;
      inv_q        <= inv_d;
    end
  end

  assign busy             = (state_q == SCAN);
  assign resp_from_client = resp_q;
  assign opt_found        = opt_found_q;
  assign opt_score        = opt_score_q;
  assign opt_col          = opt_col_q;
  assign opt_rotation     = opt_rot_q;

endmodule

// File: tb/tb_placement_search.sv
// Self-checking bench for placement_search: a timeline/result model checked
// every cycle, directed cases with literal expectations, and random requests.
module tb_placement_search;

  localparam int COLS    = 10;
  localparam int ROWS    = 2;
  localparam int COL_W   = 4;
  localparam int SCORE_W = 3;
  localparam int RW      = ROWS * COLS;

  typedef struct packed {
    logic               found;
    logic [SCORE_W-1:0] score;
    logic [COL_W-1:0]   col;
    logic [1:0]         rot;
  } res_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               req_to_client = 1'b0;
  logic [3:0]         cur_block = 4'd0;
  logic [3:0]         rot_mask = 4'd0;
  logic [RW-1:0]      row_info = '0;
  logic               resp_from_client;
  logic               busy;
  logic [COL_W-1:0]   opt_col;
  logic [1:0]         opt_rotation;
  logic               opt_found;
  logic [SCORE_W-1:0] opt_score;

  int n_checks = 0;
  int n_pass   = 0;

  placement_search #(
    .COLS (COLS), .ROWS (ROWS), .COL_W (COL_W), .SCORE_W (SCORE_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_to_client    (req_to_client),
    .cur_block        (cur_block),
    .rot_mask         (rot_mask),
    .row_info         (row_info),
    .resp_from_client (resp_from_client),
    .busy             (busy),
    .opt_col          (opt_col),
    .opt_rotation     (opt_rotation),
    .opt_found        (opt_found),
    .opt_score        (opt_score)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Footprint width straight from the piece table.
  function automatic int width_of(input int piece, input int rot);
    if (piece == 0) return (rot % 2 == 1) ? 1 : 4;
    if (piece == 1) return 2;
    return (rot % 2 == 1) ? 2 : 3;
  endfunction

  // Exhaustive search: best score wins, earliest (rot, col) wins ties.
  function automatic res_t ref_search(input int piece, input logic [3:0] mask,
                                      input logic [RW-1:0] rows);
    res_t r;
    int   best;
    r    = '0;
    best = 0;
    for (int rot = 0; rot < 4; rot++) begin
      for (int col = 0; col < COLS; col++) begin
        int w;
        int s;
        w = width_of(piece, rot);
        if (!mask[rot] || (col + w > COLS)) continue;
        s = 0;
        for (int row = 0; row < ROWS; row++) begin
          bit free;
          free = 1'b1;
          for (int c = col; c < col + w; c++)
            if (rows[row*COLS + c]) free = 1'b0;
          if (!free) break;
          s++;
        end
        if (s > best) begin
          best    = s;
          r.found = 1'b1;
          r.score = SCORE_W'(s);
          r.col   = COL_W'(col);
          r.rot   = 2'(rot);
        end
      end
    end
    return r;
  endfunction

  // Behavioural timeline: a valid request answers 4*COLS edges later,
  // an invalid one answers on the following edge.
  int   m_left;
  logic m_busy, m_resp, m_inv;
  res_t m_out, m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_busy <= 1'b0;
      m_resp <= 1'b0;
      m_inv  <= 1'b0;
      m_out  <= '0;
    end else begin
      m_resp <= 1'b0;
      m_inv  <= 1'b0;
      if (m_inv) begin
        m_resp <= 1'b1;
        m_out  <= '0;
      end
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_resp <= 1'b1;
          m_out  <= m_pend;
        end
      end else if (req_to_client) begin
        if (cur_block < 4'd7) begin
          m_busy <= 1'b1;
          m_left <= 4 * COLS;
          m_pend <= ref_search(int'(cur_block), rot_mask, row_info);
        end else begin
          m_inv <= 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(posedge clk) begin
    #1;
    chk("busy", int'(busy), int'(m_busy));
    chk("resp", int'(resp_from_client), int'(m_resp));
    chk("opt_found", int'(opt_found), int'(m_out.found));
    chk("opt_score", int'(opt_score), int'(m_out.score));
    chk("opt_col", int'(opt_col), int'(m_out.col));
    chk("opt_rotation", int'(opt_rotation), int'(m_out.rot));
  end

  // One request; lat = edges from the sampling edge to the response.
  task automatic do_req(input int piece, input logic [3:0] mask,
                        input logic [RW-1:0] rows, output int lat);
    logic [31:0] rnd;
    @(negedge clk);
    req_to_client = 1'b1;
    cur_block     = piece[3:0];
    rot_mask      = mask;
    row_info      = rows;
    @(posedge clk);
    @(negedge clk);
    req_to_client = 1'b0;
    rnd           = $urandom;
    row_info      = rnd[RW-1:0];
    cur_block     = rnd[31:28];
    rot_mask      = rnd[27:24];
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (resp_from_client) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) chk("resp_timeout", 0, 1);
    $display("req piece=%0d mask=%b rows=%h lat=%0d found=%0d score=%0d col=%0d rot=%0d",
             piece, mask, rows, lat, opt_found, opt_score, opt_col, opt_rotation);
  endtask

  task automatic chk_out(input string name, input res_t exp);
    chk({name, "_found"}, int'(opt_found), int'(exp.found));
    chk({name, "_score"}, int'(opt_score), int'(exp.score));
    chk({name, "_col"}, int'(opt_col), int'(exp.col));
    chk({name, "_rot"}, int'(opt_rotation), int'(exp.rot));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int           lat, first, second, cyc;
    logic [RW-1:0] b_empty, b_case2, b_hole, b_full, rows;
    logic [31:0]  r1, r2;
    res_t         e_o, e_i4, e_i2, e_none;

    b_empty = '0;
    b_case2 = {10'b1111111111, 10'b0000001111};
    b_hole  = {10'b1111111011, 10'b1111111011};
    b_full  = '1;
    e_o     = '{found: 1'b1, score: 3'd2, col: 4'd0, rot: 2'd0};
    e_i4    = '{found: 1'b1, score: 3'd1, col: 4'd4, rot: 2'd0};
    e_i2    = '{found: 1'b1, score: 3'd2, col: 4'd2, rot: 2'd1};
    e_none  = '0;

    // Hand-computed cases pin the reference model.
    chk("model_empty_O", int'(ref_search(1, 4'b1111, b_empty)), int'(e_o));
    chk("model_I_col4", int'(ref_search(0, 4'b0001, b_case2)), int'(e_i4));
    chk("model_I_hole_rot1", int'(ref_search(0, 4'b0010, b_hole)), int'(e_i2));
    chk("model_I_hole_rot0", int'(ref_search(0, 4'b0001, b_hole)), int'(e_none));
    chk("model_full_T", int'(ref_search(2, 4'b1111, b_full)), int'(e_none));

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_resp", int'(resp_from_client), 0);
    chk_out("reset", e_none);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases with literal expectations.
    do_req(1, 4'b1111, b_empty, lat);
    chk("lat_empty_O", lat, 40);
    chk_out("empty_O", e_o);
    do_req(0, 4'b0001, b_case2, lat);
    chk("lat_I_col4", lat, 40);
    chk_out("I_col4", e_i4);
    do_req(0, 4'b0010, b_hole, lat);
    chk_out("I_hole_rot1", e_i2);
    do_req(0, 4'b0001, b_hole, lat);
    chk_out("I_hole_rot0", e_none);
    do_req(2, 4'b1111, b_full, lat);
    chk("lat_full_T", lat, 40);
    chk_out("full_T", e_none);
    do_req(1, 4'b1111, b_empty, lat);
    do_req(9, 4'b1111, b_empty, lat);
    chk("lat_invalid", lat, 1);
    chk_out("invalid", e_none);

    // Request held high through a scan: second scan starts at edge 41.
    @(negedge clk);
    req_to_client = 1'b1;
    cur_block     = 4'd1;
    rot_mask      = 4'b1111;
    row_info      = b_empty;
    @(posedge clk);
    cyc = 0; first = 0; second = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      cyc++;
      #1;
      if (resp_from_client) begin
        if (first == 0) first = cyc;
        else begin
          second = cyc;
          break;
        end
      end
      if (cyc == 41) begin
        @(negedge clk);
        req_to_client = 1'b0;
      end
    end
    chk("b2b_first", first, 40);
    chk("b2b_second", second, 81);
    chk_out("b2b", e_o);

    // Reset in the middle of a scan aborts it without a response.
    do_req(0, 4'b0001, b_case2, lat);
    @(negedge clk);
    req_to_client = 1'b1;
    cur_block     = 4'd1;
    rot_mask      = 4'b1111;
    row_info      = b_empty;
    @(posedge clk);
    @(negedge clk);
    req_to_client = 1'b0;
    repeat (19) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_resp", int'(resp_from_client), 0);
    chk_out("midreset", e_none);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    chk("midreset_no_resp", int'(resp_from_client), 0);
    do_req(0, 4'b0001, b_case2, lat);
    chk("lat_after_reset", lat, 40);
    chk_out("after_reset", e_i4);

    // Random requests; the every-cycle checker compares against the model.
    for (int k = 0; k < 40; k++) begin
      int p;
      p = $urandom_range(0, 9);
      if (p >= 7) p = $urandom_range(7, 15);
      r1 = $urandom;
      r2 = $urandom;
      case ($urandom_range(0, 2))
        0:       rows = r1[RW-1:0] & r2[RW-1:0];
        1:       rows = r1[RW-1:0] | r2[RW-1:0];
        default: rows = r1[RW-1:0];
      endcase
      do_req(p, 4'($urandom_range(0, 15)), rows, lat);
      chk("lat_random", lat, (p <= 6) ? 40 : 1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (2) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/placement_search.md
# placement_search

Multi-cycle placement search engine for the tile-drop game logic. It replaces the single-cycle 2-row O/I column picker with a parametrised version:
- arbitrary board width and number of inspected rows;
- all seven tetrominoes in all four rotations, with a per-request rotation enable mask;
- a reported fit score.

It sits between the game controller (request side) and the drop/rotate executor (response side). It evaluates one candidate per clock and returns the best anchor column and rotation.

## Interface
- COLS, 10, board width in columns (4..15)
- ROWS, 2, number of surface rows inspected (1..4)
- COL_W, 4, width of column indices; must hold COLS-1
- SCORE_W, 3, width of the score; must hold ROWS

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_to_client  in  1  request strobe, sampled only in IDLE
- cur_block  in  4  piece: 0=I 1=O 2=T 3=S 4=Z 5=J 6=L; 7..15 invalid
- rot_mask  in  4  bit r=1 enables rotation r
- row_info  in  ROWS*COLS  row r at [r*COLS +: COLS]; row 0 is the landing surface, higher r lies deeper; bit c = column c from the left; 1 = occupied
- resp_from_client  out  1  one-cycle response strobe
- busy  out  1  high while scanning
- opt_col  out  COL_W  leftmost column of the chosen footprint
- opt_rotation  out  2  chosen rotation
- opt_found  out  1  a candidate with score ≥1 exists
- opt_score  out  SCORE_W  score of the chosen candidate

## Operation
- **States.**
  - IDLE: busy=0.
  - SCAN: busy=1.
- **Request accept.** IDLE with req_to_client=1 and cur_block ≤6:
  - latch cur_block, rot_mask and row_info;
  - clear the candidate counters (rot=0, col=0) and best = {found 0, score 0, col 0, rot 0};
  - go to SCAN.
- **Invalid piece.** IDLE with req_to_client=1 and cur_block ≥7:
  - stay in IDLE;
  - register opt_found=0, opt_score=0, opt_col=0, opt_rotation=0;
  - pulse resp_from_client.
- **Footprint width.** w(piece, rot) comes from the package table:
  - I: 4,1,4,1
  - O: 2,2,2,2
  - T/S/Z/J/L: 3,2,3,2
- **Per-candidate evaluation.** One candidate per SCAN cycle, in order rot 0..3 outer, col 0..COLS-1 inner.
  - A candidate is legal iff rot_mask[rot]=1 and col+w ≤ COLS.
  - Score = count of consecutive rows starting at row 0 in which columns col..col+w-1 are all 0. Range 0..ROWS.
  - Illegal candidates still consume their cycle. Latency is fixed.
- **Best update.** A legal candidate replaces best only if its score is strictly greater. Ties therefore keep the lowest rotation, then the lowest column.
- **End of scan.** On the edge that evaluates rot=3, col=COLS-1:
  - register the final best onto the opt_* outputs;
  - set resp_from_client=1;
  - go to IDLE.
- **No fit.** If no candidate scores ≥1: opt_found=0, opt_col=0, opt_rotation=0, opt_score=0.
- **Output hold.** opt_* hold their value until the next response. They never change mid-scan.
- **Requests during SCAN.** req_to_client is ignored; there is no queueing.
- **Input stability.** row_info changes after acceptance do not affect the result.

## Timing
- **Reset values.** rst_n low forces, immediately and asynchronously:
  - state IDLE;
  - busy, resp_from_client, opt_found = 0;
  - opt_col, opt_rotation, opt_score = 0.
- **Valid request.** Request sampled at edge 0:
  - busy is high from edge 0 to edge 4*COLS;
  - resp_from_client is high for the cycle between edge 4*COLS and edge 4*COLS+1 (40 cycles at COLS=10).
- **Back-to-back.** busy=0 during the response cycle, so a request sampled at edge 4*COLS+1 is accepted.
- **Invalid request.** resp_from_client is high for the cycle between edge 1 and edge 2; busy stays 0.
- **Response pulse.** resp_from_client is exactly one cycle wide. It clears on the next edge unless a new invalid request re-asserts it.
- **Reset mid-scan.** The scan is aborted and no response is issued. The first request after rst_n deasserts behaves normally.

## Structure
- **Package placement_pkg:**
  - piece enum: I, O, T, S, Z, J, L;
  - NUM_PIECES=7, NUM_ROT=4;
  - footprint width function/table w(piece, rot);
  - state enum: IDLE, SCAN.
- **Sub-module placement_score** (combinational):
  - inputs: latched row_info, col, w;
  - outputs: legal-width flag and score;
  - parametrised by COLS, ROWS, SCORE_W.
- **Top level:** FSM, candidate counters, best registers and output registers.

## Test plan
- COLS=10, ROWS=2, empty board, O, rot_mask=1111 → resp at cycle 40; col 0, rot 0, found 1, score 2.
- row0=10'b0000001111 (cols 0-3 occupied), row1 all 1, I, rot_mask=0001 → col 4, rot 0, score 1, found 1.
- row0 and row1 = 10'b1111111011 (only col 2 free), I, rot_mask=0010 → col 2, rot 1, score 2; same board with rot_mask=0001 → found 0, col 0, rot 0.
- Board all 1, T, rot_mask=1111 → found 0, score 0, col 0, rot 0, resp still at cycle 40.
- cur_block=9 → resp one cycle after the sample, busy never high, found 0; req_to_client held high through a valid scan → second scan starts at edge 41, second resp at cycle 81.
- rst_n pulsed low at cycle 20 of a scan → outputs and busy 0 immediately, no resp; next request gives a correct result at +40.
